// File: rtl/uart_pkg.sv
// Types and line levels shared by the UART transmitter and receiver.
package uart_pkg;

  // Transmit frame sequencing. PARITY is only visited when parity is built in.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } tx_state_t;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

endpackage : uart_pkg

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// Bit timing comes from an external one-cycle baud tick.
// Build option: define UART_TX_PARITY_EN to add a parity bit (PARITY_ODD picks the sense).
//
// Handshake: a byte is transferred on a rising i_clk edge where i_valid and
// o_ready are both high. o_ready is registered and stays low from the accept
// until the edge that ends the last stop bit; i_valid/i_data are ignored
// meanwhile. The line is registered, so every transition appears in the cycle
// after the tick that causes it.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_baud_tick,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic                 o_tx,
  output logic                 o_busy,
  output tx_state_t            o_state    // debug view of the frame sequencer
);

  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 tx_q, tx_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;

`ifdef UART_TX_PARITY_EN
  // The shift register is consumed as bits go out, so parity uses a copy.
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 parity_bit;
  assign parity_bit = (^data_q) ^ 1'(PARITY_ODD);
`else
  logic unused_parity_cfg;
  assign unused_parity_cfg = (PARITY_ODD != 0);
`endif

  // State and output registers; reset parks the line idle and drops any frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_q       <= UART_IDLE_LEVEL;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      data_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
`ifdef UART_TX_PARITY_EN
      data_q     <= data_d;
`endif
    end
  end

  // Next-state logic; the line level is computed for the state being entered.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    ready_d    = ready_q;
    busy_d     = busy_q;
`ifdef UART_TX_PARITY_EN
    data_d     = data_q;
`endif
    unique case (state_q)
      IDLE: begin
        tx_d = UART_IDLE_LEVEL;
        if (i_valid && ready_q) begin
          state_d    = ARM;
          shreg_d    = i_data;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          ready_d    = 1'b0;
          busy_d     = 1'b1;
`ifdef UART_TX_PARITY_EN
          data_d     = i_data;
`endif
        end
      end
      // Waits for a tick after the accept so the start bit is a full bit time.
      ARM: begin
        if (i_baud_tick) begin
          state_d = START;
          tx_d    = UART_START_LEVEL;
        end
      end
      START: begin
        if (i_baud_tick) begin
          state_d = DATA;
          tx_d    = shreg_q[0];
        end
      end
      DATA: begin
        if (i_baud_tick) begin
          shreg_d   = shreg_q >> 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = parity_bit;
`else
            state_d = STOP;
            tx_d    = UART_IDLE_LEVEL;
`endif
          end else begin
            tx_d = shreg_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (i_baud_tick) begin
          state_d = STOP;
          tx_d    = UART_IDLE_LEVEL;
        end
      end
`endif
      STOP: begin
        tx_d = UART_IDLE_LEVEL;
        if (i_baud_tick) begin
          if (stop_cnt_q == LAST_STOP) begin
            state_d = IDLE;
            ready_d = 1'b1;
            busy_d  = 1'b0;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = UART_IDLE_LEVEL;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign o_tx    = tx_q;
  assign o_ready = ready_q;
  assign o_busy  = busy_q;
  assign o_state = state_q;

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx (DATA_BITS=8, STOP_BITS=1, even parity when
// UART_TX_PARITY_EN is defined). Inputs are driven and outputs sampled on the
// falling clock edge.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int PODD = 0;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FL = 1 + 8 + P + 1;     // frame length in bit times
  localparam int SLOW = 139;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tick = 1'b0;
  logic [7:0] data = 8'h00;
  logic       valid = 1'b0;
  logic       ready, tx, busy;
  tx_state_t  st;
  int         tick_period = 1;
  int         tick_cnt = 0;

  always #5 clk = ~clk;

  uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(PODD)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_baud_tick(tick),
    .i_data     (data),
    .i_valid    (valid),
    .o_ready    (ready),
    .o_tx       (tx),
    .o_busy     (busy),
    .o_state    (st)
  );

  // Baud tick: constantly high for period 1, else one cycle every period.
  initial forever begin
    @(negedge clk);
    if (tick_period <= 1) begin
      tick = 1'b1;
      tick_cnt = 0;
    end else begin
      tick_cnt = tick_cnt + 1;
      if (tick_cnt >= tick_period) begin
        tick = 1'b1;
        tick_cnt = 0;
      end else begin
        tick = 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  logic       last_par = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (P == 1 && k == 9) return (^d) ^ 1'(PODD);
    return 1'b1;
  endfunction

  // ---------------- driver tasks (tick constantly high) ----------------
  task automatic send_check(input logic [7:0] d, input string tag);
    int errs;
    logic [7:0] got;
    errs = 0;
    got  = '0;
    @(negedge clk);
    check_val({tag, "_rdy_pre"}, ready, 1);
    valid = 1'b1;
    data  = d;
    @(negedge clk);
    valid = 1'b0;
    check_val({tag, "_arm"}, {tx, ready, busy}, 3'b101);
    for (int k = 0; k < FL; k++) begin
      @(negedge clk);
      if (tx !== exp_bit(d, k)) errs++;
      if (ready !== 1'b0) errs++;
      if (k >= 1 && k <= 8) got[k-1] = tx;
      if (P == 1 && k == 9) last_par = tx;
    end
    check_val({tag, "_bits"}, errs, 0);
    check_val({tag, "_decode"}, got, d);
    @(negedge clk);
    check_val({tag, "_done"}, {tx, ready, busy}, 3'b110);
  endtask

  // ---------------- stimulus ----------------
  logic       s[0:2*FL+3];
  logic [7:0] dec;
  int         errs5 [0:FL-1];
  int         lat;
  bit         found;

  initial begin
    // 1: reset and idle hold
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_outs", {tx, ready, busy}, 3'b110);
    check_val("rst_state", st, IDLE);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    begin
      int e1;
      e1 = 0;
      repeat (20) begin
        @(negedge clk);
        if ({tx, ready, busy} !== 3'b110) e1++;
      end
      check_val("idle_hold20", e1, 0);
    end

    // 2 / 3: single frames
    send_check(8'h55, "f55");
    if (P == 1) check_val("par55", last_par, 1'b0);
    send_check(8'h07, "f07");
    if (P == 1) check_val("par07", last_par, 1'b1);
    send_check(8'h80, "f80");

    // 4: back-to-back with i_valid held high
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'h3C);
    @(negedge clk);
    valid = 1'b1;
    data  = 8'hA3;
    for (int i = 0; i < 2*FL+4; i++) begin
      @(negedge clk);
      s[i] = tx;
      if (i == 0) data = 8'h3C;
      if (i == FL+2) valid = 1'b0;
      if (i == FL+1) check_val("b2b_rdy_gap", ready, 1);
    end
    check_val("b2b_start1", s[1], 0);
    check_val("b2b_gap", {s[FL], s[FL+1], s[FL+2]}, 3'b111);
    check_val("b2b_start2", s[FL+3], 0);
    check_val("b2b_stop2", s[2*FL+2], 1);
    for (int i = 0; i < 8; i++) dec[i] = s[2+i];
    check_val("b2b_byte1", dec, exp_q.pop_front());
    for (int i = 0; i < 8; i++) dec[i] = s[FL+4+i];
    check_val("b2b_byte2", dec, exp_q.pop_front());
    check_val("b2b_end", {tx, ready, busy}, 3'b110);

    // 5: slow tick, 0xFF, stray i_valid pulses during the frame
    tick_period = SLOW;
    repeat (3) @(negedge clk);
    check_val("s5_rdy_pre", ready, 1);
    valid = 1'b1;
    data  = 8'hFF;
    @(negedge clk);
    valid = 1'b0;
    data  = 8'h00;
    lat   = 0;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (tx === 1'b0) found = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    check_val("s5_start_seen", found, 1);
    if (found) begin
      check_val("s5_latency", (lat >= 1 && lat <= SLOW), 1);
      for (int b = 0; b < FL; b++) errs5[b] = 0;
      for (int k = 0; k < FL*SLOW; k++) begin
        if (k > 0) @(negedge clk);
        if (tx !== exp_bit(8'hFF, k / SLOW)) errs5[k / SLOW]++;
        if (ready !== 1'b0 || busy !== 1'b1) errs5[k / SLOW]++;
        if (k == 300 || k == 800) valid = 1'b1;
        if (k == 301 || k == 801) valid = 1'b0;
      end
      for (int b = 0; b < FL; b++) check_val($sformatf("s5_bit%0d", b), errs5[b], 0);
      @(negedge clk);
      check_val("s5_done", {tx, ready, busy}, 3'b110);
      begin
        int e5;
        e5 = 0;
        repeat (300) begin
          @(negedge clk);
          if (tx !== 1'b1 || busy !== 1'b0) e5++;
        end
        check_val("s5_no_extra", e5, 0);
      end
    end
    valid = 1'b0;
    tick_period = 1;
    repeat (2) @(negedge clk);

    // 6: reset in the middle of data bit 3
    valid = 1'b1;
    data  = 8'hF0;                       // bit 3 is 0, so the line is low there
    @(negedge clk);
    valid = 1'b0;
    for (int i = 1; i <= 5; i++) @(negedge clk);
    check_val("s6_bit3_low", tx, 0);
    #2 rst_n = 1'b0;
    #1;
    check_val("s6_rst_async", {tx, ready, busy}, 3'b110);
    check_val("s6_rst_state", st, IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int e6;
      e6 = 0;
      repeat (5) begin
        @(negedge clk);
        if ({tx, ready, busy} !== 3'b110) e6++;
      end
      check_val("s6_no_resume", e6, 0);
    end
    send_check(8'h96, "s6_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time limit so a stuck design still reaches the summary.
  initial begin
    #2_000_000;
    n_err++;
    $display("FAIL timeout: got no completion expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_uart_tx
